// File: rtl/fixed_encoder_n.sv
// Fixed-polynomial LPC residual encoder (orders 0..4) with per-block warmup passthrough.
// Input capture, history/index stage, partial sums, then final sum and warmup mux; 3-cycle latency.
module fixed_encoder_n #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned RES_WIDTH    = SAMPLE_WIDTH + 4
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic                           iValid,
  input  logic                           iBlockStart,
  input  logic [2:0]                     iOrder,
  input  logic signed [SAMPLE_WIDTH-1:0] iSample,
  output logic signed [RES_WIDTH-1:0]    oResidual,
  output logic                           oWarmup,
  output logic [2:0]                     oOrder,
  output logic                           oBlockStart,
  output logic                           oValid
);

  localparam logic [2:0] MAX_ORDER = 3'd4;

  // Accepted sample and its block controls
  logic                           in_valid;
  logic                           in_block_start;
  logic [2:0]                     in_order;
  logic signed [SAMPLE_WIDTH-1:0] in_sample;

  // S1: current sample plus history, index and order in force
  logic signed [RES_WIDTH-1:0] x0, x1, x2, x3, x4;
  logic                        s1_valid;
  logic                        s1_block_start;
  logic [2:0]                  s1_index;
  logic [2:0]                  s1_order;
  logic [2:0]                  order_clamped_c;

  // S2: partial sums split into positive and negative coefficient terms
  logic signed [RES_WIDTH-1:0] pos_sum_c, neg_sum_c;
  logic signed [RES_WIDTH-1:0] s2_sample, s2_pos, s2_neg;
  logic                        s2_valid;
  logic                        s2_block_start;
  logic                        s2_warmup;
  logic [2:0]                  s2_order;

  assign order_clamped_c = (in_order > MAX_ORDER) ? MAX_ORDER : in_order;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      in_valid       <= 1'b0;
      in_block_start <= 1'b0;
      in_order       <= '0;
      in_sample      <= '0;
    end else begin
      in_valid       <= iValid;
      in_block_start <= iValid & iBlockStart;
      if (iValid) begin
        in_order  <= iOrder;
        in_sample <= iSample;
      end
    end
  end

  // History and index move only on accepted samples; gaps leave them untouched
  always_ff @(posedge iClock) begin
    if (iReset) begin
      x0             <= '0;
      x1             <= '0;
      x2             <= '0;
      x3             <= '0;
      x4             <= '0;
      s1_valid       <= 1'b0;
      s1_block_start <= 1'b0;
      s1_index       <= '0;
      s1_order       <= '0;
    end else begin
      s1_valid       <= in_valid;
      s1_block_start <= in_block_start;
      if (in_valid) begin
        x0 <= RES_WIDTH'(in_sample);
        x1 <= x0;
        x2 <= x1;
        x3 <= x2;
        x4 <= x3;
        if (in_block_start) begin
          s1_order <= order_clamped_c;
          s1_index <= '0;
        end else if (s1_index != MAX_ORDER) begin
          s1_index <= s1_index + 3'd1;
        end
      end
    end
  end

  // Binomial coefficients built from shifts and adds only
  always_comb begin
    pos_sum_c = x0;
    neg_sum_c = '0;
    case (s1_order)
      3'd1: neg_sum_c = x1;
      3'd2: begin
        pos_sum_c = x0 + x2;
        neg_sum_c = x1 <<< 1;
      end
      3'd3: begin
        pos_sum_c = x0 + (x2 <<< 1) + x2;
        neg_sum_c = (x1 <<< 1) + x1 + x3;
      end
      3'd4: begin
        pos_sum_c = x0 + (x2 <<< 2) + (x2 <<< 1) + x4;
        neg_sum_c = (x1 <<< 2) + (x3 <<< 2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      s2_valid       <= 1'b0;
      s2_block_start <= 1'b0;
      s2_warmup      <= 1'b0;
      s2_order       <= '0;
      s2_sample      <= '0;
      s2_pos         <= '0;
      s2_neg         <= '0;
    end else begin
      s2_valid       <= s1_valid;
      s2_block_start <= s1_block_start;
      if (s1_valid) begin
        s2_warmup <= (s1_index < s1_order);
        s2_order  <= s1_order;
        s2_sample <= x0;
        s2_pos    <= pos_sum_c;
        s2_neg    <= neg_sum_c;
      end
    end
  end

  // Output stage holds data across idle cycles; block start is a single-cycle flag
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oValid      <= 1'b0;
      oBlockStart <= 1'b0;
      oResidual   <= '0;
      oWarmup     <= 1'b0;
      oOrder      <= '0;
    end else begin
      oValid      <= s2_valid;
      oBlockStart <= s2_valid & s2_block_start;
      if (s2_valid) begin
        oResidual <= s2_warmup ? s2_sample : (s2_pos - s2_neg);
        oWarmup   <= s2_warmup;
        oOrder    <= s2_order;
      end
    end
  end

endmodule

// File: tb/tb_fixed_encoder_n.sv
// Bench for fixed_encoder_n: vector table and random stream feed a scoreboard
// that a negedge monitor drains, checking data, flags and fixed latency.
module tb_fixed_encoder_n;

  localparam int unsigned SW = 16;
  localparam int unsigned RW = 20;

  logic                 iClock = 1'b0;
  logic                 iReset = 1'b1;
  logic                 iValid = 1'b0;
  logic                 iBlockStart = 1'b0;
  logic [2:0]           iOrder = '0;
  logic signed [SW-1:0] iSample = '0;
  logic signed [RW-1:0] oResidual;
  logic                 oWarmup;
  logic [2:0]           oOrder;
  logic                 oBlockStart;
  logic                 oValid;

  fixed_encoder_n #(.SAMPLE_WIDTH(SW), .RES_WIDTH(RW)) dut (
    .iClock(iClock), .iReset(iReset), .iValid(iValid), .iBlockStart(iBlockStart),
    .iOrder(iOrder), .iSample(iSample), .oResidual(oResidual), .oWarmup(oWarmup),
    .oOrder(oOrder), .oBlockStart(oBlockStart), .oValid(oValid)
  );

  always #5 iClock = ~iClock;

  int cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [RW-1:0] res;
    logic                 warm;
    logic [2:0]           ord;
    logic                 bs;
    int                   due;
    int                   id;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic       v;
    logic       bs;
    logic [2:0] ord;
    int         smp;
    int         eres;
    logic       ew;
    logic [2:0] eo;
  } vec_t;
  vec_t tbl[$];

  int next_id = 0;

  task automatic chk(input string name, input int id, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s (item %0d): got %0d, expected %0d", name, id, act, req);
    end
  endtask

  // One input cycle; accepted samples push their expectation with due cycle
  task automatic step(input logic v, input logic bs, input logic [2:0] ord, input int smp,
                      input longint er, input logic ew, input logic [2:0] eo);
    @(negedge iClock);
    iValid      = v;
    iBlockStart = bs;
    iOrder      = ord;
    iSample     = SW'(smp);
    if (v) begin
      sb.push_back('{res: RW'(er), warm: ew, ord: eo, bs: bs, due: cyc + 4, id: next_id});
      next_id++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 0, 0, 1'b0, 3'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_valid"}, -1, longint'(oValid), 0);
    chk({name, "_residual"}, -1, longint'(oResidual), 0);
    chk({name, "_warmup"}, -1, longint'(oWarmup), 0);
    chk({name, "_order"}, -1, longint'(oOrder), 0);
    chk({name, "_blockstart"}, -1, longint'(oBlockStart), 0);
  endtask

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", -1, 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("residual", mon_e.id, longint'(oResidual), longint'(mon_e.res));
          chk("warmup", mon_e.id, longint'(oWarmup), longint'(mon_e.warm));
          chk("order", mon_e.id, longint'(oOrder), longint'(mon_e.ord));
          chk("blockstart", mon_e.id, longint'(oBlockStart), longint'(mon_e.bs));
          chk("latency_cycle", mon_e.id, longint'(cyc), longint'(mon_e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        chk("missing_valid", mon_e.id, 0, 1);
      end
    end
  end

  longint mh[4];
  int     midx, mord;
  longint r;
  logic   rv, rbs, rw;
  logic [2:0] rord;
  int     rsmp;

  initial begin
    // order 2 ramp
    tbl.push_back('{1'b1, 1'b1, 3'd2, 0, 0, 1'b1, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 1, 1, 1'b1, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 4, 2, 1'b0, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 9, 2, 1'b0, 3'd2});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 16, 2, 1'b0, 3'd2});
    // order 4 on squares
    tbl.push_back('{1'b1, 1'b1, 3'd4, 0, 0, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 1, 1, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 4, 4, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 9, 9, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 16, 0, 1'b0, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 25, 0, 1'b0, 3'd4});
    // full-scale alternation, order 4 gain
    tbl.push_back('{1'b1, 1'b1, 3'd4, 32767, 32767, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, -32768, -32768, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32767, 32767, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, -32768, -32768, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32767, 524280, 1'b0, 3'd4});
    // back-to-back blocks, order 1 then order 3
    tbl.push_back('{1'b1, 1'b1, 3'd1, 5, 5, 1'b1, 3'd1});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 7, 2, 1'b0, 3'd1});
    tbl.push_back('{1'b1, 1'b1, 3'd3, 10, 10, 1'b1, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 10, 10, 1'b1, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 10, 10, 1'b1, 3'd3});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 10, 0, 1'b0, 3'd3});
    // order 7 clamps to 4; an unqualified block start mid-block is ignored
    tbl.push_back('{1'b1, 1'b1, 3'd7, 1, 1, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 3, 3, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 5, 5, 1'b1, 3'd4});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 99, 0, 1'b0, 3'd0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 7, 7, 1'b1, 3'd4});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 20, 11, 1'b0, 3'd4});

    // reset state
    repeat (3) @(negedge iClock);
    check_all_zero("reset");
    iReset = 1'b0;

    foreach (tbl[i])
      step(tbl[i].v, tbl[i].bs, tbl[i].ord, tbl[i].smp, longint'(tbl[i].eres), tbl[i].ew, tbl[i].eo);
    idle(6);

    // first block again with two idle cycles between samples
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, tbl[i].bs, tbl[i].ord, tbl[i].smp, longint'(tbl[i].eres), tbl[i].ew, tbl[i].eo);
      idle(2);
    end
    idle(6);

    // reset with two samples in flight discards them
    step(1'b1, 1'b1, 3'd1, 100, 100, 1'b1, 3'd1);
    step(1'b1, 1'b0, 3'd0, 200, 100, 1'b0, 3'd1);
    @(negedge iClock);
    iValid = 1'b0;
    iBlockStart = 1'b0;
    iReset = 1'b1;
    sb.delete();
    @(negedge iClock);
    iReset = 1'b0;
    check_all_zero("after_reset");
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("flushed_no_valid", i, longint'(oValid), 0);
    end
    step(1'b1, 1'b0, 3'd3, 42, 42, 1'b0, 3'd0);
    idle(6);

    // random stream with gaps and block starts against a reference model
    @(negedge iClock);
    iReset = 1'b1;
    iValid = 1'b0;
    @(negedge iClock);
    iReset = 1'b0;
    for (int k = 0; k < 4; k++) mh[k] = 0;
    midx = 0;
    mord = 0;
    for (int n = 0; n < 120; n++) begin
      rv   = ($urandom_range(9) < 7);
      rbs  = ($urandom_range(7) == 0);
      rord = 3'($urandom_range(7));
      rsmp = int'($urandom_range(65535)) - 32768;
      if (rv) begin
        if (rbs) begin
          mord = (rord > 3'd4) ? 4 : int'(rord);
          midx = 0;
        end else if (midx < 4) begin
          midx++;
        end
        case (mord)
          1:       r = rsmp - mh[0];
          2:       r = rsmp - 2 * mh[0] + mh[1];
          3:       r = rsmp - 3 * mh[0] + 3 * mh[1] - mh[2];
          4:       r = rsmp - 4 * mh[0] + 6 * mh[1] - 4 * mh[2] + mh[3];
          default: r = rsmp;
        endcase
        rw = (midx < mord);
        if (rw) r = rsmp;
        mh[3] = mh[2];
        mh[2] = mh[1];
        mh[1] = mh[0];
        mh[0] = rsmp;
        step(1'b1, rbs, rord, rsmp, r, rw, 3'(mord));
      end else begin
        step(1'b0, rbs, rord, rsmp, 0, 1'b0, 3'd0);
      end
    end
    idle(8);
    chk("scoreboard_drained", -1, longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_encoder_n.md
Name: fixed_encoder_n

Overview:
- Parametrised fixed-polynomial LPC residual encoder. Supports runtime-selectable order 0–4, configurable sample width, and full-precision residuals with no wrap.
- Tracks block boundaries. The first `order` samples of each block are emitted verbatim as warmup.
- Sits between the sample framer and the Rice encoder. One instance runs per channel.

Parameters:
- SAMPLE_WIDTH, 16, signed input sample width (4..32).
- RES_WIDTH, SAMPLE_WIDTH+4, signed residual width. Must be ≥ SAMPLE_WIDTH+4; order-4 gain is 16.

Ports:
- iClock  in  1  clock; all state updates on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  1  iSample (and iBlockStart/iOrder) valid this cycle.
- iBlockStart  in  1  qualifies the current valid sample as index 0 of a new block.
- iOrder  in  3  predictor order; sampled only when iValid&iBlockStart.
- iSample  in  SAMPLE_WIDTH  signed input sample.
- oResidual  out  RES_WIDTH  signed residual, or sign-extended warmup sample.
- oWarmup  out  1  oResidual is a verbatim warmup sample.
- oOrder  out  3  order in force for this output sample.
- oBlockStart  out  1  output sample is index 0 of its block.
- oValid  out  1  outputs valid this cycle.

Behaviour:
Reset (synchronous, iReset=1 at a rising edge):
- History x1..x4 = 0; all pipeline registers = 0.
- Sample index = 0; latched order = 0.
- All outputs 0.
- In-flight samples are discarded; no oValid for them afterwards.
- Reset takes priority over iValid in the same cycle.

Acceptance:
- A sample is accepted on any rising edge with iValid=1.
- There is no backpressure; iValid may gap arbitrarily.
- History and index advance only on accepted samples. Gaps do not disturb history.
- iBlockStart or iOrder with iValid=0 is ignored.

Order latch:
- On accept with iBlockStart=1: latched order = min(iOrder,4), since values 5–7 act as 4. Index for this sample = 0.
- Otherwise index = previous index+1, saturating at 4.
- Before any iBlockStart after reset, order 0 applies.

Arithmetic (x0 = current sample; x1..x4 = previous accepted samples, any block):
- order 0: x0
- order 1: x0−x1
- order 2: x0−2x1+x2
- order 3: x0−3x1+3x2−x3
- order 4: x0−4x1+6x2−4x3+x4
- Compute at RES_WIDTH with sign-extension; the result is exact and never saturates or wraps.
- Multiplies are shift/add only; no multipliers.

Warmup:
- If index < order: oResidual = sign-extended x0, oWarmup=1.
- Otherwise oResidual = formula result, oWarmup=0.
- Because of this, previous-block history never contaminates an emitted residual.

Pipeline:
- 3 stages:
  - S1: register sample, index, order; shift history.
  - S2: partial sums.
  - S3: final sum and warmup mux.
- Sample accepted at edge k → oValid=1 with its outputs after edge k+3. Fixed latency, independent of order.
- Per-sample order/index/blockstart ride the pipeline. Samples of an old block in flight when a new block starts complete with their own order.
- Throughput: 1 sample/cycle.
- oValid=0 cycles hold the previous oResidual/oWarmup/oOrder values; oBlockStart=0.

Test Plan:
1. Reset; block start with iOrder=2; samples 0,1,4,9,16 back-to-back → 3 cycles after the first accept: oResidual 0,1,2,2,2; oWarmup 1,1,0,0,0; oBlockStart 1,0,0,0,0; oOrder=2.
2. iOrder=4; samples 0,1,4,9,16,25 → 0,1,4,9 (warmup), then 0,0.
3. Overflow, iOrder=4, SAMPLE_WIDTH=16; samples 32767,−32768,32767,−32768,32767 → fifth output 524280, oWarmup=0, no wrap.
4. Scenario 1 with 2 idle cycles between each sample → identical residual sequence. Each oValid occurs exactly 3 cycles after its accept.
5. Back-to-back blocks:
   - Block A: order 1, samples 5,7.
   - Block B starts on the next cycle: iOrder=3, samples 10,10,10,10.
   - Outputs 5(w),2 | 10(w),10(w),10(w),0. oOrder switches 1→3 exactly at B's first output.
   - iOrder=7 on another block behaves as 4.
6. Assert iReset for 1 cycle while 2 samples are in flight → no oValid for them; all outputs 0. The next sample without iBlockStart is passed through as order 0.
